// File: rtl/hyperbus_axi_err_slave_if.sv
// Bus bundle for the HyperBus error stub: cfg register port plus the AXI slave channels.
// The slave modport is the stub side; master is the SoC/interconnect side.
interface hyperbus_axi_err_slave_if #(
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned AXI_DW = 16,
  parameter int unsigned AXI_IW = 10,
  parameter int unsigned AXI_UW = 1
);
  logic [31:0]         cfg_addr;
  logic                cfg_write;
  logic [31:0]         cfg_wdata;
  logic [3:0]          cfg_wstrb;
  logic                cfg_valid;
  logic [31:0]         cfg_rdata;
  logic                cfg_error;
  logic                cfg_ready;

  logic [AXI_IW-1:0]   aw_id;
  logic [AXI_AW-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic                aw_valid;
  logic                aw_ready;

  logic [AXI_DW-1:0]   w_data;
  logic [AXI_DW/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;

  logic [AXI_IW-1:0]   b_id;
  logic [1:0]          b_resp;
  logic [AXI_UW-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [AXI_IW-1:0]   ar_id;
  logic [AXI_AW-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic                ar_valid;
  logic                ar_ready;

  logic [AXI_IW-1:0]   r_id;
  logic [AXI_DW-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [AXI_UW-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport slave (
    input  cfg_addr, cfg_write, cfg_wdata, cfg_wstrb, cfg_valid,
    output cfg_rdata, cfg_error, cfg_ready,
    input  aw_id, aw_addr, aw_len, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport master (
    output cfg_addr, cfg_write, cfg_wdata, cfg_wstrb, cfg_valid,
    input  cfg_rdata, cfg_error, cfg_ready,
    output aw_id, aw_addr, aw_len, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
endinterface

// File: rtl/hyperbus_axi_err_slave.sv
// Stand-in for an absent HyperBus controller: every AXI burst completes with ERR_RESP and the
// cfg port always answers. Define HYPERBUS_STUB_SCRATCH_EN for scratch words and error counters.
module hyperbus_axi_err_slave #(
  parameter int unsigned AXI_AW     = 32,
  parameter int unsigned AXI_DW     = 16,
  parameter int unsigned AXI_IW     = 10,
  parameter int unsigned AXI_UW     = 1,
  parameter logic [1:0]  ERR_RESP   = 2'b11,
  parameter int unsigned NR_SCRATCH = 4
) (
  input logic                     clk_sys_i,
  input logic                     rst_ni,
  hyperbus_axi_err_slave_if.slave bus_io
);

  localparam logic [1:0] WIdle = 2'd0;
  localparam logic [1:0] WData = 2'd1;
  localparam logic [1:0] WResp = 2'd2;
  localparam logic       RIdle = 1'b0;
  localparam logic       RData = 1'b1;

  // Write channel
  logic [1:0]        wstate_q, wstate_d;
  logic [AXI_IW-1:0] wid_q, wid_d;
  logic              aw_ready_q, aw_ready_d;
  logic              w_ready_q, w_ready_d;
  logic              b_valid_q, b_valid_d;
  logic              aw_hs, w_last_hs, b_hs;

  assign aw_hs     = aw_ready_q & bus_io.aw_valid;
  assign w_last_hs = w_ready_q & bus_io.w_valid & bus_io.w_last;
  assign b_hs      = b_valid_q & bus_io.b_ready;

  // Only w_last ends the burst; aw_len is not compared against the beat count.
  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    case (wstate_q)
      WIdle: begin
        if (aw_hs) begin
          wstate_d = WData;
          wid_d    = bus_io.aw_id;
        end
      end
      WData:   if (w_last_hs) wstate_d = WResp;
      WResp:   if (b_hs) wstate_d = WIdle;
      default: wstate_d = WIdle;
    endcase
    aw_ready_d = (wstate_d == WIdle);
    w_ready_d  = (wstate_d == WData);
    b_valid_d  = (wstate_d == WResp);
  end

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate_q   <= WIdle;
      wid_q      <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      wstate_q   <= wstate_d;
      wid_q      <= wid_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
    end
  end

  // Read channel
  logic              rstate_q, rstate_d;
  logic [AXI_IW-1:0] rid_q, rid_d;
  logic [7:0]        rlen_q, rlen_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic              ar_ready_q, ar_ready_d;
  logic              r_valid_q, r_valid_d;
  logic              ar_hs, r_hs, r_last;

  assign ar_hs  = ar_ready_q & bus_io.ar_valid;
  assign r_hs   = r_valid_q & bus_io.r_ready;
  assign r_last = r_valid_q & (rcnt_q == rlen_q);

  // The counter leaves RData on the last beat, so len=255 never wraps it.
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    case (rstate_q)
      RIdle: begin
        if (ar_hs) begin
          rstate_d = RData;
          rid_d    = bus_io.ar_id;
          rlen_d   = bus_io.ar_len;
          rcnt_d   = 8'd0;
        end
      end
      RData: begin
        if (r_hs) begin
          if (r_last) rstate_d = RIdle;
          else        rcnt_d   = rcnt_q + 8'd1;
        end
      end
      default: rstate_d = RIdle;
    endcase
    ar_ready_d = (rstate_d == RIdle);
    r_valid_d  = (rstate_d == RData);
  end

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rstate_q   <= RIdle;
      rid_q      <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
    end else begin
      rstate_q   <= rstate_d;
      rid_q      <= rid_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
    end
  end

  assign bus_io.aw_ready = aw_ready_q;
  assign bus_io.w_ready  = w_ready_q;
  assign bus_io.b_valid  = b_valid_q;
  assign bus_io.b_id     = b_valid_q ? wid_q : '0;
  assign bus_io.b_resp   = b_valid_q ? ERR_RESP : 2'b00;
  assign bus_io.b_user   = {AXI_UW{1'b0}};
  assign bus_io.ar_ready = ar_ready_q;
  assign bus_io.r_valid  = r_valid_q;
  assign bus_io.r_id     = r_valid_q ? rid_q : '0;
  assign bus_io.r_data   = {AXI_DW{1'b0}};
  assign bus_io.r_resp   = r_valid_q ? ERR_RESP : 2'b00;
  assign bus_io.r_last   = r_last;
  assign bus_io.r_user   = {AXI_UW{1'b0}};

  // cfg port: a completion blocks acceptance for one cycle, so ready never stays high.
  logic        cfg_req;
  logic        cfg_ready_q, cfg_ready_d;
  logic        cfg_error_q, cfg_error_d;
  logic [31:0] cfg_rdata_q, cfg_rdata_d;

  assign cfg_req     = bus_io.cfg_valid & ~cfg_ready_q;
  assign cfg_ready_d = cfg_req;

`ifdef HYPERBUS_STUB_SCRATCH_EN
  localparam int unsigned IdxW = (NR_SCRATCH > 1) ? $clog2(NR_SCRATCH) : 1;

  logic [29:0]     word;
  logic [IdxW-1:0] idx;
  logic [31:0]     scratch_q [NR_SCRATCH];
  logic [31:0]     scratch_d [NR_SCRATCH];
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [15:0]     rd_cnt_q, rd_cnt_d;

  assign word = bus_io.cfg_addr[31:2];
  assign idx  = word[IdxW-1:0];

  always_comb begin
    scratch_d   = scratch_q;
    cfg_rdata_d = '0;
    cfg_error_d = 1'b0;
    if (cfg_req) begin
      if (word < 30'(NR_SCRATCH)) begin
        if (bus_io.cfg_write) begin
          for (int b = 0; b < 4; b++) begin
            if (bus_io.cfg_wstrb[b]) scratch_d[idx][8*b +: 8] = bus_io.cfg_wdata[8*b +: 8];
          end
        end else begin
          cfg_rdata_d = scratch_q[idx];
        end
      end else if (word == 30'(NR_SCRATCH)) begin
        if (bus_io.cfg_write) cfg_error_d = 1'b1;
        else                  cfg_rdata_d = {rd_cnt_q, wr_cnt_q};
      end else begin
        cfg_error_d = 1'b1;
      end
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (b_hs && (wr_cnt_q != 16'hFFFF))          wr_cnt_d = wr_cnt_q + 16'd1;
    if (r_hs && r_last && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scratch_q <= '{default: '0};
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      scratch_q <= scratch_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end
`else
  assign cfg_rdata_d = '0;
  assign cfg_error_d = cfg_req;
`endif

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_ready_q <= 1'b0;
      cfg_error_q <= 1'b0;
      cfg_rdata_q <= '0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      cfg_error_q <= cfg_error_d;
      cfg_rdata_q <= cfg_rdata_d;
    end
  end

  assign bus_io.cfg_ready = cfg_ready_q;
  assign bus_io.cfg_error = cfg_error_q;
  assign bus_io.cfg_rdata = cfg_rdata_q;

  logic [AXI_AW-1:0] unused_addr;
  logic              unused_in;
  assign unused_addr = bus_io.aw_addr ^ bus_io.ar_addr;
  assign unused_in   = ^{unused_addr, bus_io.aw_len, bus_io.w_data, bus_io.w_strb,
                         bus_io.cfg_addr, bus_io.cfg_write, bus_io.cfg_wdata, bus_io.cfg_wstrb,
                         (NR_SCRATCH != 0)};

endmodule

// File: tb/tb_hyperbus_axi_err_slave.sv
// Bench for hyperbus_axi_err_slave: directed sequence with randomized ids, lengths, stalls and cfg
// traffic, checked against a transaction-level model of the error stub.
module tb_hyperbus_axi_err_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 10;
  localparam int unsigned UW = 1;
  localparam int unsigned NS = 4;
  localparam logic [1:0]  ERR = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hyperbus_axi_err_slave_if #(.AXI_AW(AW), .AXI_DW(DW), .AXI_IW(IW), .AXI_UW(UW)) bus_if ();

  hyperbus_axi_err_slave #(
    .AXI_AW    (AW),
    .AXI_DW    (DW),
    .AXI_IW    (IW),
    .AXI_UW    (UW),
    .ERR_RESP  (ERR),
    .NR_SCRATCH(NS)
  ) dut (
    .clk_sys_i(clk),
    .rst_ni   (rst_n),
    .bus_io   (bus_if)
  );

  int tests = 0;
  int fails = 0;
  // Model state: completed error bursts and scratch contents since last reset.
  int n_wr = 0;
  int n_rd = 0;
  logic [31:0] scr [NS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    n_wr = 0;
    n_rd = 0;
    for (int i = 0; i < NS; i++) scr[i] = '0;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input int len, input int beats,
                           input int b_wait);
    int cyc;
    bus_if.aw_id    = id;
    bus_if.aw_addr  = $urandom;
    bus_if.aw_len   = 8'(len);
    bus_if.aw_valid = 1'b1;
    cyc = 0;
    while (!bus_if.aw_ready && cyc < 50) begin step(); cyc++; end
    chk("aw_ready_seen", bus_if.aw_ready, 1'b1);
    step();
    bus_if.aw_valid = 1'b0;
    chk("aw_taken", {bus_if.aw_ready, bus_if.w_ready, bus_if.b_valid}, 3'b010);
    for (int i = 0; i < beats; i++) begin
      if ($urandom_range(3) == 0) begin bus_if.w_valid = 1'b0; step(); end
      bus_if.w_data  = 16'($urandom);
      bus_if.w_strb  = 2'($urandom);
      bus_if.w_valid = 1'b1;
      bus_if.w_last  = (i == beats - 1);
      step();
    end
    bus_if.w_valid = 1'b0;
    bus_if.w_last  = 1'b0;
    chk("b_latency", {bus_if.b_valid, bus_if.b_id, bus_if.b_resp, bus_if.w_ready},
        {1'b1, id, ERR, 1'b0});
    for (int k = 0; k < b_wait; k++) begin
      step();
      chk("b_hold", {bus_if.aw_ready, bus_if.b_valid, bus_if.b_id, bus_if.b_resp},
          {1'b0, 1'b1, id, ERR});
    end
    bus_if.b_ready = 1'b1;
    step();
    bus_if.b_ready = 1'b0;
    chk("b_done", {bus_if.b_valid, bus_if.aw_ready}, 2'b01);
    n_wr++;
  endtask

  task automatic axi_read(input logic [IW-1:0] id, input int len, input int stall_pct);
    int cyc;
    int beat;
    int f0;
    bit hs;
    bus_if.ar_id    = id;
    bus_if.ar_addr  = $urandom;
    bus_if.ar_len   = 8'(len);
    bus_if.ar_valid = 1'b1;
    cyc = 0;
    while (!bus_if.ar_ready && cyc < 50) begin step(); cyc++; end
    chk("ar_ready_seen", bus_if.ar_ready, 1'b1);
    step();
    bus_if.ar_valid = 1'b0;
    chk("r_first", {bus_if.ar_ready, bus_if.r_valid}, 2'b01);
    beat = 0;
    cyc  = 0;
    f0   = fails;
    while (beat <= len && cyc < 2000 && fails == f0) begin
      // Expected beat depends only on its index, so a stalled beat must repeat unchanged.
      chk("r_beat", {bus_if.r_valid, bus_if.r_id, bus_if.r_data, bus_if.r_resp, bus_if.r_last,
                     bus_if.r_user},
          {1'b1, id, {DW{1'b0}}, ERR, (beat == len), {UW{1'b0}}});
      bus_if.r_ready = ($urandom_range(99) >= stall_pct);
      hs = bus_if.r_ready && bus_if.r_valid;
      step();
      if (hs) beat++;
      cyc++;
    end
    bus_if.r_ready = 1'b0;
    chk("r_count", beat, len + 1);
    chk("r_done", {bus_if.r_valid, bus_if.ar_ready}, 2'b01);
    n_rd++;
  endtask

  task automatic cfg_acc(input string tag, input logic [31:0] addr, input bit wr,
                         input logic [31:0] wd, input logic [3:0] ws);
    int widx;
    logic [31:0] exp_rd;
    bit exp_err;
    widx    = int'(addr[31:2]);
    exp_rd  = '0;
    exp_err = 1'b1;
`ifdef HYPERBUS_STUB_SCRATCH_EN
    if (widx < NS) begin
      exp_err = 1'b0;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (ws[b]) scr[widx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = scr[widx];
      end
    end else if (widx == NS) begin
      exp_err = wr;
      if (!wr) exp_rd = {(n_rd > 65535) ? 16'hFFFF : 16'(n_rd),
                         (n_wr > 65535) ? 16'hFFFF : 16'(n_wr)};
    end
`endif
    chk("cfg_quiet", {bus_if.cfg_ready, bus_if.cfg_error, bus_if.cfg_rdata}, 34'h0);
    bus_if.cfg_addr  = addr;
    bus_if.cfg_write = wr;
    bus_if.cfg_wdata = wd;
    bus_if.cfg_wstrb = ws;
    bus_if.cfg_valid = 1'b1;
    step();
    chk(tag, {bus_if.cfg_ready, bus_if.cfg_error, bus_if.cfg_rdata}, {1'b1, exp_err, exp_rd});
    bus_if.cfg_valid = 1'b0;
    step();
    chk("cfg_pulse", {bus_if.cfg_ready, bus_if.cfg_error, bus_if.cfg_rdata}, 34'h0);
  endtask

  initial begin
    int rb;
    logic [IW-1:0] idw;
    logic [IW-1:0] idr;
    int word;

    bus_if.cfg_addr = '0; bus_if.cfg_write = 1'b0; bus_if.cfg_wdata = '0;
    bus_if.cfg_wstrb = '0; bus_if.cfg_valid = 1'b0;
    bus_if.aw_id = '0; bus_if.aw_addr = '0; bus_if.aw_len = '0; bus_if.aw_valid = 1'b0;
    bus_if.w_data = '0; bus_if.w_strb = '0; bus_if.w_last = 1'b0; bus_if.w_valid = 1'b0;
    bus_if.b_ready = 1'b0;
    bus_if.ar_id = '0; bus_if.ar_addr = '0; bus_if.ar_len = '0; bus_if.ar_valid = 1'b0;
    bus_if.r_ready = 1'b0;
    model_reset();

    repeat (3) step();
    chk("rst_ctrl", {bus_if.aw_ready, bus_if.w_ready, bus_if.b_valid, bus_if.ar_ready,
                     bus_if.r_valid, bus_if.r_last, bus_if.cfg_ready, bus_if.cfg_error}, 8'h00);
    chk("rst_data", {bus_if.b_id, bus_if.b_resp, bus_if.r_id, bus_if.r_resp, bus_if.r_data,
                     bus_if.cfg_rdata}, 64'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst", {bus_if.aw_ready, bus_if.ar_ready, bus_if.w_ready, bus_if.b_valid,
                     bus_if.r_valid}, 5'b11000);

    axi_write(10'd5, 3, 4, 3);
    axi_read(10'd7, 0, 0);

    for (int i = 0; i < 4; i++) begin
      axi_write(10'($urandom), $urandom_range(255), $urandom_range(1, 6), $urandom_range(4));
      axi_read(10'($urandom), $urandom_range(12), $urandom_range(60));
    end

    // W presented before AW must wait.
    bus_if.w_valid = 1'b1;
    bus_if.w_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w_before_aw", {bus_if.w_ready, bus_if.b_valid}, 2'b00);
    end
    axi_write(10'h3A5, 1, 2, 1);

    axi_read(10'h155, 255, 50);

    // Simultaneous AW/AR; B held off while the R burst drains.
    idw = 10'($urandom);
    idr = 10'($urandom);
    chk("cc_ready", {bus_if.aw_ready, bus_if.ar_ready}, 2'b11);
    bus_if.aw_id = idw; bus_if.aw_len = 8'd0; bus_if.aw_valid = 1'b1;
    bus_if.ar_id = idr; bus_if.ar_len = 8'd5; bus_if.ar_valid = 1'b1;
    step();
    bus_if.aw_valid = 1'b0;
    bus_if.ar_valid = 1'b0;
    chk("cc_taken", {bus_if.aw_ready, bus_if.ar_ready, bus_if.w_ready, bus_if.r_valid}, 4'b0011);
    rb = 0;
    for (int c = 0; c < 12; c++) begin
      bus_if.w_valid = (c == 0);
      bus_if.w_last  = (c == 0);
      bus_if.r_ready = 1'b1;
      if (c >= 1) chk("cc_b_hold", {bus_if.b_valid, bus_if.b_id, bus_if.b_resp}, {1'b1, idw, ERR});
      if (bus_if.r_valid) begin
        chk("cc_r_beat", {bus_if.r_id, bus_if.r_resp, bus_if.r_last}, {idr, ERR, (rb == 5)});
        rb++;
      end
      step();
    end
    bus_if.w_valid = 1'b0;
    bus_if.w_last  = 1'b0;
    bus_if.r_ready = 1'b0;
    chk("cc_r_count", rb, 6);
    chk("cc_r_idle", {bus_if.r_valid, bus_if.ar_ready, bus_if.b_valid}, 3'b011);
    bus_if.b_ready = 1'b1;
    step();
    bus_if.b_ready = 1'b0;
    chk("cc_b_done", {bus_if.b_valid, bus_if.aw_ready}, 2'b01);
    n_wr++;
    n_rd++;

    // Reset in the middle of a read burst drops it.
    bus_if.ar_id = 10'd9; bus_if.ar_len = 8'd20; bus_if.ar_valid = 1'b1;
    step();
    bus_if.ar_valid = 1'b0;
    bus_if.r_ready  = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_r", {bus_if.r_valid, bus_if.r_last, bus_if.b_valid}, 3'b000);
    bus_if.r_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    chk("rst_mid_idle", {bus_if.ar_ready, bus_if.r_valid, bus_if.b_valid}, 3'b100);
    axi_read(10'd11, 2, 20);

    for (int i = 0; i < 3; i++) axi_write(10'($urandom), $urandom_range(7), $urandom_range(1, 4), 0);
    axi_read(10'($urandom), $urandom_range(5), 30);

    cfg_acc("cfg_wr0", 32'h0, 1'b1, 32'hDEAD_BEEF, 4'hF);
    cfg_acc("cfg_rd0", 32'h0, 1'b0, 32'h0, 4'h0);
    cfg_acc("cfg_wr1", 32'h4, 1'b1, 32'hA5A5_1234, 4'b0011);
    cfg_acc("cfg_rd1", 32'h4, 1'b0, 32'h0, 4'h0);
    cfg_acc("cfg_status", NS * 4, 1'b0, 32'h0, 4'h0);
    cfg_acc("cfg_status_wr", NS * 4, 1'b1, 32'hFFFF_FFFF, 4'hF);
    cfg_acc("cfg_oob", (NS + 1) * 4, 1'b0, 32'h0, 4'h0);

    // Valid held high: completions must be spaced by a gap cycle.
    bus_if.cfg_addr  = (NS + 1) * 4;
    bus_if.cfg_write = 1'b0;
    bus_if.cfg_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("cfg_b2b", {bus_if.cfg_ready, bus_if.cfg_error}, (c % 2 == 0) ? 2'b11 : 2'b00);
      if (c == 2) bus_if.cfg_valid = 1'b0;
    end
    step();

    for (int i = 0; i < 12; i++) begin
      word = $urandom_range(NS + 2);
      cfg_acc("cfg_rand", {30'(word), 2'($urandom)}, 1'($urandom), $urandom, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion by 500000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
